axis_serdes_tx_lanes: RTL and testbench



---
 rtl/axis_serdes_pkg.sv | 24 ++
 rtl/axis_hold_reg.sv | 61 ++++++
 rtl/axis_serdes_tx_lanes.sv | 193 +++++++++++++++++++
 tb/tb_axis_serdes_tx_lanes.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_serdes_pkg.sv
// Shared definitions for the serdes lane transmitter (and its RX counterpart).
// Contents:
//   state_t       - transmit FSM states
//   START_BIT     - line level driven during the start bit
//   IDLE_LEVEL    - line level driven while idle / in the inter-frame gap
//   bit_cnt_width - width of a counter able to hold 0..bpl
package axis_serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_PAR,
    ST_GAP
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

  function automatic int bit_cnt_width(input int bpl);
    return $clog2(bpl + 1);
  endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// One-entry valid/ready holding register in front of the lane serializer.
// Ports:
//   clk, srst  - clock and synchronous active-high reset
//   wr_data    - word offered by the stream source
//   wr_valid   - source has a word
//   wr_ready   - registered, equals !full outside reset (low during reset)
//   data       - held word
//   full       - a word is held
//   pop        - consumer takes the held word this edge
module axis_hold_reg
  import axis_serdes_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] data,
  output logic             full,
  input  logic             pop
);

  logic             full_reg;
  logic             full_next;
  logic             ready_reg;
  logic             accept;
  logic [WIDTH-1:0] data_reg;

  // ready is low whenever a word is held, so accept and pop never coincide.
  assign accept = wr_valid && ready_reg;

  always_comb begin
    full_next = full_reg;
    if (accept) begin
      full_next = 1'b1;
    end else if (pop) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      full_reg  <= 1'b0;
      ready_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      full_reg  <= full_next;
      ready_reg <= !full_next;
      if (accept) begin
        data_reg <= wr_data;
      end
    end
  end

  assign wr_ready = ready_reg;
  assign data     = data_reg;
  assign full     = full_reg;

endmodule

// File: rtl/axis_serdes_tx_lanes.sv
// AXI-stream transmit serializer striping each word across NUM_LANES lanes.
// Lane k carries tdata[k*BPL +: BPL]; each frame is a start bit (all lanes 1),
// BPL data bits LSB-first, an optional even-parity bit, then MIN_IDLE zeros.
// Optional feature: define AXIS_SERDES_PARITY_EN to add the per-lane parity bit.
// Ports:
//   tx_clk, tx_reset - bit clock, synchronous active-high reset
//   s_axis_tdata/valid/ready - stream slave (one-entry holding register)
//   tx_lane      - serial lane outputs (registered)
//   busy         - frame in progress (START/SHIFT/PAR/GAP)
//   frame_count  - frames fully sent, wraps
module axis_serdes_tx_lanes
  import axis_serdes_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LANES   = 1,
  parameter int MIN_IDLE    = 2,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   tx_clk,
  input  logic                   tx_reset,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_valid,
  output logic                   s_axis_ready,
  output logic [NUM_LANES-1:0]   tx_lane,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int BPL   = DATA_WIDTH / NUM_LANES;
  localparam int CNT_W = bit_cnt_width(BPL);
  localparam int GAP_W = (MIN_IDLE < 1) ? 1 : $clog2(MIN_IDLE + 1);
  localparam logic [CNT_W-1:0] BPL_CNT  = CNT_W'(BPL);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_IDLE);

  generate
    if (NUM_LANES < 1 || (DATA_WIDTH % NUM_LANES) != 0) begin : g_bad_cfg
      $error("axis_serdes_tx_lanes: DATA_WIDTH must be a multiple of NUM_LANES >= 1");
    end
  endgenerate

  state_t                 state_reg;
  logic [NUM_LANES-1:0]   lane_reg;
  logic                   busy_reg;
  logic [FRAME_CNT_W-1:0] frame_count_reg;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [GAP_W-1:0]       gap_cnt_reg;

  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   hold_full;
  logic                   pop;
  logic                   last_bit;
  logic                   count_frame;
  logic                   frame_done;
  logic [NUM_LANES-1:0]   lsb_vec;
  logic [DATA_WIDTH-1:0]  shift_next;
`ifdef AXIS_SERDES_PARITY_EN
  logic [NUM_LANES-1:0]   par_vec;
  logic [NUM_LANES-1:0]   par_reg;
`endif

  axis_hold_reg #(.WIDTH(DATA_WIDTH)) u_hold (
    .clk      (tx_clk),
    .srst     (tx_reset),
    .wr_data  (s_axis_tdata),
    .wr_valid (s_axis_valid),
    .wr_ready (s_axis_ready),
    .data     (hold_data),
    .full     (hold_full),
    .pop      (pop)
  );

  // Each lane keeps its own slice of the shifter; all slices shift together.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [BPL-1:0] lane_bits;
      assign lane_bits                   = shift_reg[gi*BPL +: BPL];
      assign lsb_vec[gi]                 = lane_bits[0];
      assign shift_next[gi*BPL +: BPL]   = lane_bits >> 1;
`ifdef AXIS_SERDES_PARITY_EN
      assign par_vec[gi]                 = ^hold_data[gi*BPL +: BPL];
`endif
    end
  endgenerate

  // bit_cnt_reg holds how many data bits are already on the lanes.
  assign last_bit = (bit_cnt_reg == BPL_CNT);

  // frame_done marks the final cycle of a frame, where a held word can start
  // the next frame immediately without passing through IDLE.
  always_comb begin
    count_frame = 1'b0;
    frame_done  = 1'b0;
    case (state_reg)
`ifdef AXIS_SERDES_PARITY_EN
      ST_PAR: begin
        count_frame = 1'b1;
        frame_done  = (MIN_IDLE == 0);
      end
`else
      ST_SHIFT: begin
        count_frame = last_bit;
        frame_done  = last_bit && (MIN_IDLE == 0);
      end
`endif
      ST_GAP:  frame_done = (gap_cnt_reg == GAP_LAST);
      default: ;
    endcase
  end

  assign pop = hold_full && ((state_reg == ST_IDLE) || frame_done);

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state_reg       <= ST_IDLE;
      lane_reg        <= '0;
      busy_reg        <= 1'b0;
      frame_count_reg <= '0;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
`ifdef AXIS_SERDES_PARITY_EN
      par_reg         <= '0;
`endif
    end else begin
      if (count_frame) begin
        frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
      end
      if (pop) begin
        state_reg   <= ST_START;
        lane_reg    <= {NUM_LANES{START_BIT}};
        busy_reg    <= 1'b1;
        shift_reg   <= hold_data;
        bit_cnt_reg <= '0;
`ifdef AXIS_SERDES_PARITY_EN
        par_reg     <= par_vec;
`endif
      end else begin
        case (state_reg)
          ST_IDLE: begin
            lane_reg <= {NUM_LANES{IDLE_LEVEL}};
            busy_reg <= 1'b0;
          end
          ST_START: begin
            state_reg   <= ST_SHIFT;
            lane_reg    <= lsb_vec;
            shift_reg   <= shift_next;
            bit_cnt_reg <= CNT_W'(1);
          end
          ST_SHIFT: begin
            if (!last_bit) begin
              lane_reg    <= lsb_vec;
              shift_reg   <= shift_next;
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
`ifdef AXIS_SERDES_PARITY_EN
            end else begin
              state_reg <= ST_PAR;
              lane_reg  <= par_reg;
            end
          end
          ST_PAR: begin
            if (MIN_IDLE == 0) begin
`else
            end else if (MIN_IDLE == 0) begin
`endif
              state_reg <= ST_IDLE;
              lane_reg  <= {NUM_LANES{IDLE_LEVEL}};
              busy_reg  <= 1'b0;
            end else begin
              state_reg   <= ST_GAP;
              lane_reg    <= {NUM_LANES{IDLE_LEVEL}};
              gap_cnt_reg <= GAP_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_cnt_reg != GAP_LAST) begin
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_lane     = lane_reg;
  assign busy        = busy_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_axis_serdes_tx_lanes.sv
// Bench for axis_serdes_tx_lanes: three configurations run side by side
// (1 lane / gap 2 / 16-bit count, 4 lanes / gap 2 / 2-bit count,
// 4 lanes / gap 0 / 16-bit count) against a frame-queue reference model.
module tb_axis_serdes_tx_lanes;

`ifdef AXIS_SERDES_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [3:0] lanes;
    logic       last;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0][31:0] tdata_v = '0;
  logic [2:0]       valid_v = '0;
  logic             ready_0, ready_1, ready_2;
  logic             busy_0, busy_1, busy_2;
  logic [0:0]       lane_0;
  logic [3:0]       lane_1, lane_2;
  logic [15:0]      fc_0, fc_2;
  logic [1:0]       fc_1;

  always #5 clk = ~clk;

  axis_serdes_tx_lanes #(.DATA_WIDTH(32), .NUM_LANES(1), .MIN_IDLE(2), .FRAME_CNT_W(16)) dut0 (
    .tx_clk(clk), .tx_reset(rst), .s_axis_tdata(tdata_v[0]), .s_axis_valid(valid_v[0]),
    .s_axis_ready(ready_0), .tx_lane(lane_0), .busy(busy_0), .frame_count(fc_0));
  axis_serdes_tx_lanes #(.DATA_WIDTH(32), .NUM_LANES(4), .MIN_IDLE(2), .FRAME_CNT_W(2)) dut1 (
    .tx_clk(clk), .tx_reset(rst), .s_axis_tdata(tdata_v[1]), .s_axis_valid(valid_v[1]),
    .s_axis_ready(ready_1), .tx_lane(lane_1), .busy(busy_1), .frame_count(fc_1));
  axis_serdes_tx_lanes #(.DATA_WIDTH(32), .NUM_LANES(4), .MIN_IDLE(0), .FRAME_CNT_W(16)) dut2 (
    .tx_clk(clk), .tx_reset(rst), .s_axis_tdata(tdata_v[2]), .s_axis_valid(valid_v[2]),
    .s_axis_ready(ready_2), .tx_lane(lane_2), .busy(busy_2), .frame_count(fc_2));

  int checks = 0;
  int errors = 0;

  // stimulus bookkeeping
  logic [31:0] words[$];
  int          idx[3];

  // reference model state
  ent_t        mq[3][$];
  bit          m_hold[3];
  logic [31:0] m_word[3];
  int          m_count[3];
  logic [3:0]  m_lane[3];
  bit          m_busy[3];
  bit          m_ready[3];
  bit          m_last[3];

  // observation logs
  logic [3:0]  lane_log[3][$];
  int          busy_cnt[3];
  int          low_run[3];
  int          low_max[3];
  int          fc_hist[$];
  int          prev_fc1;

  function automatic int nl(input int d);
    return (d == 0) ? 1 : 4;
  endfunction
  function automatic int idle_len(input int d);
    return (d == 2) ? 0 : 2;
  endfunction
  function automatic int cw(input int d);
    return (d == 1) ? 2 : 16;
  endfunction

  function automatic logic [3:0] obs_lane(input int d);
    case (d)
      0:       return {3'b000, lane_0};
      1:       return lane_1;
      default: return lane_2;
    endcase
  endfunction
  function automatic logic [15:0] obs_fc(input int d);
    case (d)
      0:       return fc_0;
      1:       return {14'd0, fc_1};
      default: return fc_2;
    endcase
  endfunction
  function automatic logic obs_busy(input int d);
    case (d)
      0:       return busy_0;
      1:       return busy_1;
      default: return busy_2;
    endcase
  endfunction
  function automatic logic obs_ready(input int d);
    case (d)
      0:       return ready_0;
      1:       return ready_1;
      default: return ready_2;
    endcase
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Expand one word into the per-cycle lane vectors of its frame.
  function automatic void push_frame(input int d, input logic [31:0] w);
    int   l = nl(d);
    int   b = 32 / l;
    ent_t e;
    e.lanes = 4'((1 << l) - 1);
    e.last  = 1'b0;
    mq[d].push_back(e);
    for (int i = 0; i < b; i++) begin
      e.lanes = '0;
      for (int k = 0; k < l; k++) e.lanes[k] = w[k*b + i];
      e.last = (i == b - 1) && (PAR == 0);
      mq[d].push_back(e);
    end
    if (PAR == 1) begin
      e.lanes = '0;
      for (int k = 0; k < l; k++) begin
        logic p = 1'b0;
        for (int i = 0; i < b; i++) p = p ^ w[k*b + i];
        e.lanes[k] = p;
      end
      e.last = 1'b1;
      mq[d].push_back(e);
    end
    for (int g = 0; g < idle_len(d); g++) begin
      e = '0;
      mq[d].push_back(e);
    end
  endfunction

  // Advance the model by one rising edge.
  function automatic void model_step(input int d, input logic r, input bit acc, input logic [31:0] data);
    ent_t e;
    if (r) begin
      mq[d].delete();
      m_hold[d] = 0; m_count[d] = 0; m_lane[d] = '0;
      m_busy[d] = 0; m_ready[d] = 0; m_last[d] = 0;
      return;
    end
    if (m_last[d]) m_count[d]++;
    if (mq[d].size() == 0 && m_hold[d]) begin
      push_frame(d, m_word[d]);
      m_hold[d] = 0;
    end
    if (mq[d].size() != 0) begin
      e = mq[d].pop_front();
      m_lane[d] = e.lanes; m_busy[d] = 1; m_last[d] = e.last;
    end else begin
      m_lane[d] = '0; m_busy[d] = 0; m_last[d] = 0;
    end
    if (acc) begin
      m_hold[d] = 1;
      m_word[d] = data;
    end
    m_ready[d] = !m_hold[d];
  endfunction

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) begin
      lane_log[d].delete();
      busy_cnt[d] = 0; low_run[d] = 0; low_max[d] = 0;
    end
  endtask

  task automatic step(input int gap_pct);
    bit acc;
    for (int d = 0; d < 3; d++) begin
      if (!rst && idx[d] < words.size() && int'($urandom_range(99)) >= gap_pct) begin
        valid_v[d] = 1'b1;
        tdata_v[d] = words[idx[d]];
      end else begin
        valid_v[d] = 1'b0;
        tdata_v[d] = $urandom;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      acc = valid_v[d] && m_ready[d] && !rst;
      model_step(d, rst, acc, tdata_v[d]);
      if (acc) idx[d]++;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("lane", d, 32'(obs_lane(d)), 32'(m_lane[d]));
      chk("busy", d, 32'(obs_busy(d)), 32'(m_busy[d]));
      chk("ready", d, 32'(obs_ready(d)), 32'(m_ready[d]));
      chk("frame_count", d, 32'(obs_fc(d)), 32'(m_count[d] % (1 << cw(d))));
      lane_log[d].push_back(obs_lane(d));
      busy_cnt[d] += int'(obs_busy(d));
      if (!obs_ready(d)) begin
        low_run[d]++;
        if (low_run[d] > low_max[d]) low_max[d] = low_run[d];
      end else begin
        low_run[d] = 0;
      end
    end
    if (int'(fc_1) != prev_fc1) begin
      fc_hist.push_back(int'(fc_1));
      prev_fc1 = int'(fc_1);
    end
  endtask

  function automatic bit all_done();
    for (int d = 0; d < 3; d++)
      if (idx[d] != words.size() || m_hold[d] || mq[d].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run(input int gap_pct);
    int n = 0;
    for (int d = 0; d < 3; d++) idx[d] = 0;
    while (!all_done() && n < 6000) begin
      step(gap_pct);
      n++;
    end
    chk("run_budget", 0, 32'(n < 6000), 32'd1);
    step(0);
    step(0);
  endtask

  function automatic int find_start(input int d, input int from);
    logic [3:0] ones = 4'((1 << nl(d)) - 1);
    for (int i = from; i < lane_log[d].size(); i++)
      if (lane_log[d][i] == ones) return i;
    return -1;
  endfunction

  function automatic logic [7:0] get_byte(input int d, input int start, input int lane);
    logic [7:0] b = '0;
    logic [3:0] v;
    for (int i = 0; i < 8; i++) begin
      if (start + i < lane_log[d].size()) begin
        v = lane_log[d][start + i];
        b[i] = v[lane];
      end
    end
    return b;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int s, s0, s1, s2, fc2_before;
    prev_fc1 = 0;
    for (int d = 0; d < 3; d++) idx[d] = 0;

    // Reset: outputs idle, ready low while reset is held.
    rst = 1'b1;
    repeat (3) step(0);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", d, 32'(obs_ready(d)), 32'd0);
      chk("rst_lane", d, 32'(obs_lane(d)), 32'd0);
      chk("rst_busy", d, 32'(obs_busy(d)), 32'd0);
      chk("rst_fc", d, 32'(obs_fc(d)), 32'd0);
    end
    rst = 1'b0;
    step(0);
    for (int d = 0; d < 3; d++) chk("post_rst_ready", d, 32'(obs_ready(d)), 32'd1);

    // Single 0xDEADBEEF on every configuration.
    clear_logs();
    w = 32'hDEADBEEF;
    words = '{32'hDEADBEEF};
    run(0);
    s = find_start(0, 0);
    chk("t1_start_found", 0, 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    for (int k = 0; k < 4; k++) chk("t1_byte", 0, 32'(get_byte(0, s + 1 + 8*k + PAR*0, 0)), 32'(w[8*k +: 8]));
    chk("t1_gap0", 0, 32'(lane_log[0][s + 33 + PAR]), 32'd0);
    chk("t1_gap1", 0, 32'(lane_log[0][s + 34 + PAR]), 32'd0);
    chk("t1_busy_cycles", 0, 32'(busy_cnt[0]), 32'(35 + PAR));
    chk("t1_fc", 0, 32'(fc_0), 32'd1);
    s = find_start(1, 0);
    chk("t2_start_found", 1, 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    for (int k = 0; k < 4; k++) chk("t2_lane_byte", 1, 32'(get_byte(1, s + 1, k)), 32'(w[8*k +: 8]));
    chk("t2_busy_cycles", 1, 32'(busy_cnt[1]), 32'(11 + PAR));
    chk("t2_fc", 1, 32'(fc_1), 32'd1);
`ifdef AXIS_SERDES_PARITY_EN
    chk("t4_parity_bits", 1, 32'(lane_log[1][s + 9]), 32'h5);
`endif

    // Three words back to back, valid held high.
    clear_logs();
    fc2_before = int'(fc_2);
    words = '{32'h1, 32'h2, 32'h3};
    run(0);
    s0 = find_start(2, 0);
    s1 = find_start(2, s0 + 1);
    s2 = find_start(2, s1 + 1);
    chk("t3_spacing01", 2, 32'(s1 - s0), 32'(9 + PAR));
    chk("t3_spacing12", 2, 32'(s2 - s1), 32'(9 + PAR));
    chk("t3_fc", 2, 32'(fc_2), 32'(fc2_before + 3));
    chk("t3_ready_low_max", 2, 32'(low_max[2] <= 9 + PAR), 32'd1);

    // Reset in the middle of SHIFT with a second word held.
    words = '{32'h12345678, 32'h9ABCDEF0};
    for (int d = 0; d < 3; d++) idx[d] = 0;
    repeat (6) step(0);
    chk("t5_busy_before", 1, 32'(busy_1), 32'd1);
    chk("t5_lane_before", 1, 32'(lane_1[0]), 32'd1);
    rst = 1'b1;
    step(0);
    for (int d = 0; d < 3; d++) begin
      chk("t5_lane_zero", d, 32'(obs_lane(d)), 32'd0);
      chk("t5_fc_zero", d, 32'(obs_fc(d)), 32'd0);
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) idx[d] = words.size();
    step(0);
    for (int d = 0; d < 3; d++) chk("t5_ready", d, 32'(obs_ready(d)), 32'd1);
    clear_logs();
    repeat (40) step(0);
    for (int d = 0; d < 3; d++) chk("t5_no_tx", d, 32'(busy_cnt[d]), 32'd0);

    // Five words with random valid gaps; 2-bit counter wraps.
    fc_hist.delete();
    prev_fc1 = int'(fc_1);
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    run(40);
    chk("t6_fc_hist_len", 1, 32'(fc_hist.size()), 32'd5);
    for (int i = 0; i < 5 && i < fc_hist.size(); i++)
      chk("t6_fc_seq", 1, 32'(fc_hist[i]), 32'((i + 1) % 4));

    // Random words and gaps against the model.
    for (int r = 0; r < 3; r++) begin
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back($urandom);
      run(int'($urandom_range(60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
